// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, the illegal-op boundary
// and the control FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  // Every code from here up to 4'hF is unsupported.
  localparam logic [3:0] OP_ILLEGAL_LO = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_LO;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle; done asserts exactly WIDTH cycles after start and holds until clear_i.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             clear_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q;
  logic             is_div_q;
  logic             sel_hi_q;

  logic             start_div;
  logic [WIDTH-1:0] src_hi, src_lo, src_m;
  logic             src_div;
  logic [WIDTH:0]   sum, shifted, diff;

  assign start_div = (op_i == OP_DIVU) || (op_i == OP_REMU);

  // The start cycle performs the first step straight from the operand ports,
  // so the last of the WIDTH steps lands WIDTH cycles after start.
  assign src_hi  = start_i ? '0 : hi_q;
  assign src_lo  = start_i ? (start_div ? a_i : b_i) : lo_q;
  assign src_m   = start_i ? (start_div ? b_i : a_i) : m_q;
  assign src_div = start_i ? start_div : is_div_q;

  always_comb begin
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    shifted = {src_hi, src_lo[WIDTH-1]};
    diff    = shifted - {1'b0, src_m};
    hi_d    = sum[WIDTH:1];
    lo_d    = {sum[0], src_lo[WIDTH-1:1]};
    if (src_div) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {src_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {src_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(1);
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= src_m;
      is_div_q <= start_div;
      sel_hi_q <= (op_i == OP_MULHU) || (op_i == OP_REMU);
    end else begin
      if (busy_q && (cnt_q != CW'(WIDTH))) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (clear_i) busy_q <= 1'b0;
    end
  end

  // Divide by zero needs no special case: every quotient bit resolves to 1
  // and the remainder shifts in A unchanged.
  assign done_o   = busy_q && (cnt_q == CW'(WIDTH));
  assign result_o = sel_hi_q ? hi_q : lo_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready on both sides: single-cycle ops return in
// one cycle, MUL/MULHU/DIVU/REMU go through the iterative sub-unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUres,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready,
  // a result on a rising edge with out_valid && out_ready; valid never waits
  // on ready, and requests seen outside IDLE are dropped, not queued.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res;
  logic             md_start, md_done, md_clear;
  logic [WIDTH-1:0] md_res;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = B[SHW-1:0];

  always_comb begin
    fast_res = '0;
    case (op)
      OP_ADD:  fast_res = A + B;
      OP_SUB:  fast_res = A - B;
      OP_XOR:  fast_res = A ^ B;
      OP_AND:  fast_res = A & B;
      OP_OR:   fast_res = A | B;
      OP_SLL:  fast_res = A << shamt;
      OP_SRL:  fast_res = A >> shamt;
      OP_SRA:  fast_res = $signed(A) >>> shamt;
      OP_SLT:  fast_res[0] = $signed(A) < $signed(B);
      OP_SLTU: fast_res[0] = A < B;
      default: fast_res = '0;
    endcase
  end

  assign md_start = accept && is_muldiv(op);
  assign md_clear = (state_q == ST_BUSY) && md_done;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .a_i      (A),
    .b_i      (B),
    .op_i     (op),
    .clear_i  (md_clear),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // The accept edge is also the IDLE->DONE edge, so single-cycle results are
  // captured there; the result register then holds them through DONE.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_muldiv(op)) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            res_d     = fast_res;
            zero_d    = (fast_res == '0);
            illegal_d = is_illegal(op);
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d   = ST_DONE;
          res_d     = md_res;
          zero_d    = (md_res == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUres      = res_q;
  assign zero        = zero_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table through a scoreboard queue,
// plus hand-written back-pressure and reset-while-busy sequences.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUres;
  logic         zero;
  logic         illegal;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUres      (ALUres),
    .zero        (zero),
    .illegal     (illegal),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ill;
  } vec_t;

  vec_t         vecs[$];
  logic [W+1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, b, res,
                              input logic z, ill);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = res; v.z = z; v.ill = ill;
    return v;
  endfunction

  function automatic int exp_latency(input logic [3:0] o);
    return (o >= 4'd10 && o <= 4'd13) ? W + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one request, pushes its expected result, then scrambles the
  // inputs right after the accept edge.
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a, b, res,
                          input logic z, ill);
    @(negedge clk);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1; A = a; B = b; op = o;
    exp_q.push_back({res, z, ill});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A  = W'($urandom);
    B  = W'($urandom);
    op = 4'($urandom_range(0, 15));
  endtask

  task automatic collect(input int lat_exp, input int hold);
    int           lat;
    bit           seen;
    logic [W+1:0] e;
    lat = 0;
    seen = 0;
    if (hold > 0) out_ready = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        lat = k;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid_timeout: got no result, expected one within 200 cycles");
      void'(exp_q.pop_front());
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    check("latency", W'(lat), W'(lat_exp));
    e = exp_q.pop_front();
    check("alures", ALUres, e[W+1:2]);
    check("zero", W'(zero), W'(e[1]));
    check("illegal", W'(illegal), W'(e[0]));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      A  = W'($urandom);
      B  = W'($urandom);
      op = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("hold_alures", ALUres, e[W+1:2]);
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("no_extra_result", W'(out_valid), W'(0));
    check("back_to_idle", W'(dbg_state), W'(0));
  endtask

  initial begin
    int extra;
    vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(4'd0,  32'd2,        32'd3,        32'd5,        1'b0, 1'b0));
    vecs.push_back(mk(4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(4'd1,  32'd7,        32'd7,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  32'h1,        32'h21,       32'h2,        1'b0, 1'b0));
    vecs.push_back(mk(4'd6,  32'h80000000, 32'h1F,       32'h1,        1'b0, 1'b0));
    vecs.push_back(mk(4'd7,  32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd8,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0));
    vecs.push_back(mk(4'd9,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(4'd10, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 32'd12345,    32'd1000,     32'h00BC5EA8, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd13, 32'd100,      32'd0,        32'd100,      1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0));
    vecs.push_back(mk(4'd13, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'd13, 32'hFFFFFFFF, 32'h10,       32'hF,        1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 32'd3,        32'd5,        32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(4'd14, 32'd9,        32'd9,        32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(4'd15, 32'h1234,     32'h5678,     32'h0,        1'b1, 1'b1));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_alures", ALUres, W'(0));
    check("rst_zero", W'(zero), W'(0));
    check("rst_illegal", W'(illegal), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].ill);
      collect(exp_latency(vecs[i].op), 0);
    end

    // Back-pressure on a finished division while the request side churns.
    drive_op(4'd12, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    collect(W + 1, 5);

    // Reset in the 10th BUSY cycle of a multiply discards it.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; A = 32'd7; B = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", W'(dbg_state), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy_state", W'(dbg_state), W'(0));
    check("rst_busy_in_ready", W'(in_ready), W'(1));
    check("rst_busy_out_valid", W'(out_valid), W'(0));
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("no_result_after_rst", W'(extra), W'(0));
    drive_op(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    collect(1, 0);

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
